// File: rtl/vga_sync_gen.sv
// ----------------------------------------------------------------------------
// vga_sync_gen
// Pixel-clock timing generator: produces the column/row position of the
// current pixel together with the matching horizontal/vertical sync pulses,
// a visible-area flag and a one-cycle start-of-frame pulse.
//
// Ports:
//   clk          in   pixel clock, rising-edge logic
//   rst          in   asynchronous, active-high reset
//   en           in   pixel-advance enable; everything holds while low
//                     (frame_start is dropped instead of held)
//   h_sync       out  registered horizontal sync, asserted level SYNC_ACTIVE
//   v_sync       out  registered vertical sync, asserted level SYNC_ACTIVE
//   col_counter  out  current column, 0..TOTAL_COLS-1
//   row_counter  out  current row, 0..TOTAL_ROWS-1
//   active       out  high inside the DISP_COLS x DISP_ROWS visible area
//   frame_start  out  one-cycle pulse when the position wraps to (0,0)
//
// All outputs are computed from the *next* position and registered in the
// same clock as the counters, so every output describes the position that
// is currently on col_counter/row_counter.
// ----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int TOTAL_COLS    = 1040,
  parameter int TOTAL_ROWS    = 666,
  parameter int DISP_COLS     = 800,
  parameter int DISP_ROWS     = 600,
  parameter int H_FRONT_PORCH = 56,
  parameter int H_SYNC_WIDTH  = 120,
  parameter int V_FRONT_PORCH = 37,
  parameter int V_SYNC_WIDTH  = 6,
  parameter bit SYNC_ACTIVE   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        h_sync,
  output logic        v_sync,
  output logic [11:0] col_counter,
  output logic [11:0] row_counter,
  output logic        active,
  output logic        frame_start
);

  // Parameter legality, rejected at elaboration.
  if (DISP_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS) begin : g_bad_h
    $error("vga_sync_gen: horizontal visible+porch+sync exceeds TOTAL_COLS");
  end
  if (DISP_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS) begin : g_bad_v
    $error("vga_sync_gen: vertical visible+porch+sync exceeds TOTAL_ROWS");
  end
  if (TOTAL_COLS > 4096 || TOTAL_ROWS > 4096) begin : g_bad_total
    $error("vga_sync_gen: TOTAL_COLS/TOTAL_ROWS must fit 12-bit counters");
  end

  localparam logic [11:0] C_LAST_COL  = 12'(TOTAL_COLS - 1);
  localparam logic [11:0] C_LAST_ROW  = 12'(TOTAL_ROWS - 1);
  localparam logic [11:0] C_DISP_COLS = 12'(DISP_COLS);
  localparam logic [11:0] C_DISP_ROWS = 12'(DISP_ROWS);
  localparam logic [11:0] C_HS_FIRST  = 12'(DISP_COLS + H_FRONT_PORCH);
  localparam logic [11:0] C_HS_LAST   = 12'(DISP_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
  localparam logic [11:0] C_VS_FIRST  = 12'(DISP_ROWS + V_FRONT_PORCH);
  localparam logic [11:0] C_VS_LAST   = 12'(DISP_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);

  logic [11:0] r_col;
  logic [11:0] r_row;
  logic        r_h_sync;
  logic        r_v_sync;
  logic        r_active;
  logic        r_frame_start;

  logic        w_col_wrap;
  logic        w_row_wrap;
  logic [11:0] w_col_nxt;
  logic [11:0] w_row_nxt;
  logic        w_h_sync_nxt;
  logic        w_v_sync_nxt;
  logic        w_active_nxt;
  logic        w_frame_start_nxt;

  // Next position and the outputs that belong to that position.
  always_comb begin
    w_col_wrap        = (r_col == C_LAST_COL);
    w_row_wrap        = (r_row == C_LAST_ROW);
    w_col_nxt         = r_col + 12'd1;
    w_row_nxt         = r_row;
    w_h_sync_nxt      = ~SYNC_ACTIVE;
    w_v_sync_nxt      = ~SYNC_ACTIVE;
    w_active_nxt      = 1'b0;
    w_frame_start_nxt = 1'b0;

    if (w_col_wrap) begin
      w_col_nxt = 12'd0;
      if (w_row_wrap) begin
        w_row_nxt         = 12'd0;
        w_frame_start_nxt = 1'b1;
      end else begin
        w_row_nxt = r_row + 12'd1;
      end
    end else begin
      w_row_nxt = r_row;
    end

    if (w_col_nxt >= C_HS_FIRST && w_col_nxt <= C_HS_LAST) begin
      w_h_sync_nxt = SYNC_ACTIVE;
    end else begin
      w_h_sync_nxt = ~SYNC_ACTIVE;
    end

    // Row only changes together with the column wrap, so v_sync can only
    // move on the clock where col_counter becomes 0.
    if (w_row_nxt >= C_VS_FIRST && w_row_nxt <= C_VS_LAST) begin
      w_v_sync_nxt = SYNC_ACTIVE;
    end else begin
      w_v_sync_nxt = ~SYNC_ACTIVE;
    end

    w_active_nxt = (w_col_nxt < C_DISP_COLS) && (w_row_nxt < C_DISP_ROWS);
  end

  // Position/output registers; frame_start is dropped (not held) while en=0
  // so it can never stretch beyond a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col         <= 12'd0;
      r_row         <= 12'd0;
      r_h_sync      <= ~SYNC_ACTIVE;
      r_v_sync      <= ~SYNC_ACTIVE;
      r_active      <= 1'b1;
      r_frame_start <= 1'b0;
    end else if (en) begin
      r_col         <= w_col_nxt;
      r_row         <= w_row_nxt;
      r_h_sync      <= w_h_sync_nxt;
      r_v_sync      <= w_v_sync_nxt;
      r_active      <= w_active_nxt;
      r_frame_start <= w_frame_start_nxt;
    end else begin
      r_frame_start <= 1'b0;
    end
  end

  assign h_sync      = r_h_sync;
  assign v_sync      = r_v_sync;
  assign col_counter = r_col;
  assign row_counter = r_row;
  assign active      = r_active;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_gen
// Three instances share clk/rst/en: default 800x600 timing, a tiny positive
// polarity configuration and a small negative polarity configuration. Every
// clock all three are compared with a position model that derives col/row
// from the number of enabled clocks since reset using division/modulo.
// ----------------------------------------------------------------------------
module tb_vga_sync_gen;

  // Tiny configuration: h_sync cols 7..8, v_sync row 6, frame = 80 clocks.
  localparam int S_TC = 10, S_TR = 8, S_DC = 6, S_DR = 5;
  localparam int S_HFP = 1, S_HSW = 2, S_VFP = 1, S_VSW = 1;
  // Negative polarity configuration: h_sync cols 13..14, v_sync row 8.
  localparam int N_TC = 16, N_TR = 10, N_DC = 12, N_DR = 7;
  localparam int N_HFP = 1, N_HSW = 2, N_VFP = 1, N_VSW = 1;

  logic clk;
  logic rst;
  logic en;

  logic        d_h, d_v, d_a, d_fs;
  logic [11:0] d_col, d_row;
  logic        s_h, s_v, s_a, s_fs;
  logic [11:0] s_col, s_row;
  logic        n_h, n_v, n_a, n_fs;
  logic [11:0] n_col, n_row;

  int n_tests;
  int n_fail;
  int t;          // enabled advances since the last reset
  bit last_en;    // whether the most recent clock advanced

  vga_sync_gen u_def (
    .clk(clk), .rst(rst), .en(en),
    .h_sync(d_h), .v_sync(d_v), .col_counter(d_col), .row_counter(d_row),
    .active(d_a), .frame_start(d_fs)
  );

  vga_sync_gen #(
    .TOTAL_COLS(S_TC), .TOTAL_ROWS(S_TR), .DISP_COLS(S_DC), .DISP_ROWS(S_DR),
    .H_FRONT_PORCH(S_HFP), .H_SYNC_WIDTH(S_HSW),
    .V_FRONT_PORCH(S_VFP), .V_SYNC_WIDTH(S_VSW), .SYNC_ACTIVE(1'b1)
  ) u_sml (
    .clk(clk), .rst(rst), .en(en),
    .h_sync(s_h), .v_sync(s_v), .col_counter(s_col), .row_counter(s_row),
    .active(s_a), .frame_start(s_fs)
  );

  vga_sync_gen #(
    .TOTAL_COLS(N_TC), .TOTAL_ROWS(N_TR), .DISP_COLS(N_DC), .DISP_ROWS(N_DR),
    .H_FRONT_PORCH(N_HFP), .H_SYNC_WIDTH(N_HSW),
    .V_FRONT_PORCH(N_VFP), .V_SYNC_WIDTH(N_VSW), .SYNC_ACTIVE(1'b0)
  ) u_neg (
    .clk(clk), .rst(rst), .en(en),
    .h_sync(n_h), .v_sync(n_v), .col_counter(n_col), .row_counter(n_row),
    .active(n_a), .frame_start(n_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (advance %0d)", name, got, exp, t);
    end
  endtask

  // Reference: position is simply the enabled-clock count folded by the
  // line and frame lengths; the rest follows from the timing rules.
  task automatic chk(input string tag, input int tc, input int tr, input int dc,
                     input int dr, input int hs0, input int hw, input int vs0,
                     input int vw, input bit sa, input logic [11:0] col,
                     input logic [11:0] row, input logic h, input logic v,
                     input logic a, input logic fs);
    int ec, er;
    bit eh, ev, ea, efs;
    ec  = t % tc;
    er  = (t / tc) % tr;
    eh  = (ec >= hs0 && ec < hs0 + hw) ? sa : !sa;
    ev  = (er >= vs0 && er < vs0 + vw) ? sa : !sa;
    ea  = (ec < dc) && (er < dr);
    efs = last_en && (t > 0) && (t % (tc * tr) == 0);
    cmp({tag, ".col"}, int'(col), ec);
    cmp({tag, ".row"}, int'(row), er);
    cmp({tag, ".h_sync"}, int'(h), int'(eh));
    cmp({tag, ".v_sync"}, int'(v), int'(ev));
    cmp({tag, ".active"}, int'(a), int'(ea));
    cmp({tag, ".frame_start"}, int'(fs), int'(efs));
  endtask

  task automatic check_models();
    chk("def", 1040, 666, 800, 600, 856, 120, 637, 6, 1'b1,
        d_col, d_row, d_h, d_v, d_a, d_fs);
    chk("sml", S_TC, S_TR, S_DC, S_DR, S_DC + S_HFP, S_HSW, S_DR + S_VFP, S_VSW,
        1'b1, s_col, s_row, s_h, s_v, s_a, s_fs);
    chk("neg", N_TC, N_TR, N_DC, N_DR, N_DC + N_HFP, N_HSW, N_DR + N_VFP, N_VSW,
        1'b0, n_col, n_row, n_h, n_v, n_a, n_fs);
  endtask

  // One clock with the given enable; outputs sampled 1 time unit after the edge.
  task automatic step(input bit e);
    en = e;
    @(posedge clk);
    #1;
    if (e) t++;
    last_en = e;
    check_models();
  endtask

  // Asserts rst between edges (checks the asynchronous effect), holds it
  // for n edges and releases it.
  task automatic do_reset(input int n);
    rst = 1'b1;
    en  = 1'b0;
    #1;
    t = 0;
    last_en = 1'b0;
    check_models();
    repeat (n) @(posedge clk);
    #1;
    check_models();
    rst = 1'b0;
  endtask

  typedef struct {
    int adv;   // enabled clocks after reset release
    int col;
    int row;
    bit h;
    bit v;
    bit act;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int fs_count, fs_first;
    bit prev_fs, prev_v;
    n_tests = 0;
    n_fail  = 0;
    t       = 0;
    last_en = 1'b0;
    rst     = 1'b0;
    en      = 1'b0;

    // Default-timing horizontal landmarks, hand-derived from 800/56/120/1040.
    tbl[0]  = '{adv: 0,    col: 0,    row: 0, h: 1'b0, v: 1'b0, act: 1'b1};
    tbl[1]  = '{adv: 1,    col: 1,    row: 0, h: 1'b0, v: 1'b0, act: 1'b1};
    tbl[2]  = '{adv: 2,    col: 2,    row: 0, h: 1'b0, v: 1'b0, act: 1'b1};
    tbl[3]  = '{adv: 799,  col: 799,  row: 0, h: 1'b0, v: 1'b0, act: 1'b1};
    tbl[4]  = '{adv: 800,  col: 800,  row: 0, h: 1'b0, v: 1'b0, act: 1'b0};
    tbl[5]  = '{adv: 855,  col: 855,  row: 0, h: 1'b0, v: 1'b0, act: 1'b0};
    tbl[6]  = '{adv: 856,  col: 856,  row: 0, h: 1'b1, v: 1'b0, act: 1'b0};
    tbl[7]  = '{adv: 975,  col: 975,  row: 0, h: 1'b1, v: 1'b0, act: 1'b0};
    tbl[8]  = '{adv: 976,  col: 976,  row: 0, h: 1'b0, v: 1'b0, act: 1'b0};
    tbl[9]  = '{adv: 1039, col: 1039, row: 0, h: 1'b0, v: 1'b0, act: 1'b0};
    tbl[10] = '{adv: 1040, col: 0,    row: 1, h: 1'b0, v: 1'b0, act: 1'b1};
    tbl[11] = '{adv: 1041, col: 1,    row: 1, h: 1'b0, v: 1'b0, act: 1'b1};

    @(posedge clk);
    #1;
    do_reset(3);
    cmp("neg.reset_h_idle_high", int'(n_h), 1);
    cmp("neg.reset_v_idle_high", int'(n_v), 1);

    for (int i = 0; i < 12; i++) begin
      while (t < tbl[i].adv) step(1'b1);
      cmp($sformatf("tbl%0d.col", i), int'(d_col), tbl[i].col);
      cmp($sformatf("tbl%0d.row", i), int'(d_row), tbl[i].row);
      cmp($sformatf("tbl%0d.h_sync", i), int'(d_h), int'(tbl[i].h));
      cmp($sformatf("tbl%0d.v_sync", i), int'(d_v), int'(tbl[i].v));
      cmp($sformatf("tbl%0d.active", i), int'(d_a), int'(tbl[i].act));
    end

    // Mid-line reset at col 500: must take effect before the next edge.
    do_reset(1);
    while (t < 500) step(1'b1);
    cmp("midline.col_before", int'(d_col), 500);
    rst = 1'b1;
    #1;
    cmp("midline.async_col", int'(d_col), 0);
    cmp("midline.async_active", int'(d_a), 1);
    cmp("midline.async_h", int'(d_h), 0);
    do_reset(2);

    // Enable gating at col 855, then h_sync asserts on the next advance.
    while (t < 855) step(1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      cmp("gate.frozen_col", int'(d_col), 855);
      cmp("gate.frozen_h", int'(d_h), 0);
    end
    step(1'b1);
    cmp("gate.resume_col", int'(d_col), 856);
    cmp("gate.resume_h", int'(d_h), 1);

    // Frame wraps on the tiny instance: 3 frames minus one clock -> 2 pulses.
    do_reset(1);
    fs_count = 0;
    fs_first = -1;
    prev_fs  = 1'b0;
    prev_v   = s_v;
    for (int i = 0; i < 3 * S_TC * S_TR - 1; i++) begin
      step(1'b1);
      if (s_fs) begin
        fs_count++;
        if (fs_first < 0) fs_first = t;
        cmp("frame.fs_at_col0", int'(s_col), 0);
        cmp("frame.fs_at_row0", int'(s_row), 0);
      end
      cmp("frame.fs_single_cycle", int'(prev_fs && s_fs), 0);
      if (s_v != prev_v) cmp("frame.v_edge_col0", int'(s_col), 0);
      prev_fs = s_fs;
      prev_v  = s_v;
    end
    cmp("frame.fs_count", fs_count, 2);
    cmp("frame.fs_first_clock", fs_first, S_TC * S_TR);

    // en=0 on the frame_start cycle drops the pulse.
    do_reset(1);
    while (t < S_TC * S_TR) step(1'b1);
    cmp("fsgate.pulse", int'(s_fs), 1);
    step(1'b0);
    cmp("fsgate.dropped", int'(s_fs), 0);
    cmp("fsgate.col_held", int'(s_col), 0);
    step(1'b0);
    cmp("fsgate.still_low", int'(s_fs), 0);

    // Randomised enable pattern with occasional resets.
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset(int'($urandom_range(1, 3)));
      else step($urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
